// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port memory bus between the instruction-fetch port (IF)
// and the data-access port (DM, driven from the EX/MEM stage). One bus
// transaction is in flight at a time. The data port normally wins, but a
// streak counter forces an IF grant after DM_STREAK consecutive DM grants
// taken while a fetch was waiting, so fetch cannot be starved.
//
// Optional feature (compile-time macro MEM_ARB_TIMEOUT_EN):
//   When defined, a busy transaction that sees no i_bus_ack for TIMEOUT
//   cycles is aborted. The port gets its done pulse with rdata = 0, and
//   o_bus_err pulses together with it. When undefined, a transaction waits
//   for its ack indefinitely and o_bus_err is tied low.
//
// Parameters
//   ADDR_W     address width
//   DATA_W     data width (multiple of 8)
//   DM_STREAK  max consecutive DM grants while IF is pending (1..3)
//   TIMEOUT    busy cycles without ack before abort (2..255)
//
// Ports
//   clk, reset         clock; asynchronous active-high reset
//   i_if_req/i_if_addr fetch request, held until o_if_valid
//   o_if_rdata         fetched word (holds between pulses)
//   o_if_valid         one-cycle fetch completion
//   o_if_stall         i_if_req & ~o_if_valid
//   i_dm_read/i_dm_write/i_dm_addr/i_dm_wdata/i_dm_be  data request
//   o_dm_rdata         load data (0 after a store; holds between pulses)
//   o_dm_done          one-cycle data completion
//   o_dm_stall         (i_dm_read | i_dm_write) & ~o_dm_done
//   o_bus_req/o_bus_we/o_bus_addr/o_bus_wdata/o_bus_be  bus request side
//   i_bus_ack/i_bus_rdata  bus completion and read data
//   o_bus_err          timeout pulse (always 0 without the macro)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DM_STREAK = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic                clk,
  input  logic                reset,
  // instruction fetch port
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic [DATA_W-1:0]   o_if_rdata,
  output logic                o_if_valid,
  output logic                o_if_stall,
  // data port
  input  logic                i_dm_read,
  input  logic                i_dm_write,
  input  logic [ADDR_W-1:0]   i_dm_addr,
  input  logic [DATA_W-1:0]   i_dm_wdata,
  input  logic [DATA_W/8-1:0] i_dm_be,
  output logic [DATA_W-1:0]   o_dm_rdata,
  output logic                o_dm_done,
  output logic                o_dm_stall,
  // memory bus
  output logic                o_bus_req,
  output logic                o_bus_we,
  output logic [ADDR_W-1:0]   o_bus_addr,
  output logic [DATA_W-1:0]   o_bus_wdata,
  output logic [DATA_W/8-1:0] o_bus_be,
  input  logic                i_bus_ack,
  input  logic [DATA_W-1:0]   i_bus_rdata,
  output logic                o_bus_err
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY_IF = 2'd1,
    S_BUSY_DM = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic              r_grant_dm;   // owner of the current/last transaction
  logic [1:0]        r_streak;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;
  logic [BE_W-1:0]   r_bus_be;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;

  logic w_dm_pend;
  logic w_force_if;
  logic w_grant_dm;
  logic w_grant_if;
  logic w_busy;
  logic w_ack;
  logic w_timeout;
  logic w_err_flag;

  // -------------------------------------------------------------------------
  // Arbitration: only decided in IDLE. DM wins unless IF has already waited
  // through DM_STREAK data grants.
  // -------------------------------------------------------------------------
  assign w_dm_pend  = i_dm_read | i_dm_write;
  assign w_force_if = i_if_req & (r_streak == 2'(DM_STREAK));
  assign w_grant_dm = (r_state == S_IDLE) & w_dm_pend & ~w_force_if;
  assign w_grant_if = (r_state == S_IDLE) & ~w_grant_dm & i_if_req;
  assign w_busy     = (r_state == S_BUSY_IF) | (r_state == S_BUSY_DM);
  // An ack is only meaningful while a transaction is outstanding.
  assign w_ack      = w_busy & i_bus_ack;

  // -------------------------------------------------------------------------
  // Optional bus timeout
  // -------------------------------------------------------------------------
`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] r_tmo_cnt;
  logic       r_tmo_flag;

  // An ack arriving in the timeout cycle takes precedence.
  assign w_timeout  = w_busy & ~i_bus_ack & (r_tmo_cnt == 8'(TIMEOUT - 1));
  assign w_err_flag = r_tmo_flag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo_cnt  <= 8'd0;
      r_tmo_flag <= 1'b0;
    end else begin
      // Held at zero outside BUSY so each transaction starts from zero.
      if (!w_busy) begin
        r_tmo_cnt <= 8'd0;
      end else if (!i_bus_ack) begin
        r_tmo_cnt <= r_tmo_cnt + 8'd1;
      end
      // DONE lasts exactly one cycle, so this marks that DONE cycle only.
      r_tmo_flag <= w_timeout;
    end
  end
`else
  assign w_timeout  = 1'b0;
  assign w_err_flag = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_dm) begin
          w_state_next = S_BUSY_DM;
        end else if (w_grant_if) begin
          w_state_next = S_BUSY_IF;
        end
      end
      S_BUSY_IF, S_BUSY_DM: begin
        if (w_ack || w_timeout) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    o_bus_req  = 1'b0;
    o_if_valid = 1'b0;
    o_dm_done  = 1'b0;
    o_bus_err  = 1'b0;
    case (r_state)
      S_BUSY_IF, S_BUSY_DM: o_bus_req = 1'b1;
      S_DONE: begin
        o_if_valid = ~r_grant_dm;
        o_dm_done  = r_grant_dm;
        o_bus_err  = w_err_flag;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: grant capture, streak, read data capture
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant_dm  <= 1'b0;
      r_streak    <= 2'd0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_be    <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      if (w_grant_dm) begin
        r_grant_dm <= 1'b1;
        r_bus_addr <= i_dm_addr;
        // A simultaneous read+write request is performed as the write.
        if (i_dm_write) begin
          r_bus_we    <= 1'b1;
          r_bus_wdata <= i_dm_wdata;
          r_bus_be    <= i_dm_be;
        end else begin
          r_bus_we    <= 1'b0;
          r_bus_wdata <= '0;
          r_bus_be    <= '1;
        end
        // Only DM grants that made a waiting fetch wait extend the streak.
        r_streak <= i_if_req ? (r_streak + 2'd1) : 2'd0;
      end else if (w_grant_if) begin
        r_grant_dm  <= 1'b0;
        r_bus_addr  <= i_if_addr;
        r_bus_we    <= 1'b0;
        r_bus_wdata <= '0;
        r_bus_be    <= '1;
        r_streak    <= 2'd0;
      end

      if (w_ack) begin
        if (r_grant_dm) begin
          r_dm_rdata <= r_bus_we ? '0 : i_bus_rdata;
        end else begin
          r_if_rdata <= i_bus_rdata;
        end
      end else if (w_timeout) begin
        if (r_grant_dm) begin
          r_dm_rdata <= '0;
        end else begin
          r_if_rdata <= '0;
        end
      end
    end
  end

  assign o_bus_we    = r_bus_we;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_wdata = r_bus_wdata;
  assign o_bus_be    = r_bus_be;
  assign o_if_rdata  = r_if_rdata;
  assign o_dm_rdata  = r_dm_rdata;

  // Stalls are purely combinational so the pipeline releases in the done cycle.
  assign o_if_stall = i_if_req & ~o_if_valid;
  assign o_dm_stall = w_dm_pend & ~o_dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Scoreboard bench for mem_port_arbiter. Directed stimulus pushes the
// expected bus transactions and port completions into queues; an
// independent monitor pops and compares whenever the DUT starts a bus
// request or pulses a completion. A small bus slave acks after a
// programmable number of busy cycles with data from an address table.
// The timeout scenario is compiled in only with MEM_ARB_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_if_req = 1'b0;
  logic [AW-1:0] i_if_addr = '0;
  logic [DW-1:0] o_if_rdata;
  logic          o_if_valid;
  logic          o_if_stall;
  logic          i_dm_read = 1'b0;
  logic          i_dm_write = 1'b0;
  logic [AW-1:0] i_dm_addr = '0;
  logic [DW-1:0] i_dm_wdata = '0;
  logic [BW-1:0] i_dm_be = '0;
  logic [DW-1:0] o_dm_rdata;
  logic          o_dm_done;
  logic          o_dm_stall;
  logic          o_bus_req;
  logic          o_bus_we;
  logic [AW-1:0] o_bus_addr;
  logic [DW-1:0] o_bus_wdata;
  logic [BW-1:0] o_bus_be;
  logic          i_bus_ack = 1'b0;
  logic [DW-1:0] i_bus_rdata = '0;
  logic          o_bus_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .DM_STREAK(2), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_rdata(o_if_rdata),
    .o_if_valid(o_if_valid), .o_if_stall(o_if_stall),
    .i_dm_read(i_dm_read), .i_dm_write(i_dm_write), .i_dm_addr(i_dm_addr),
    .i_dm_wdata(i_dm_wdata), .i_dm_be(i_dm_be), .o_dm_rdata(o_dm_rdata),
    .o_dm_done(o_dm_done), .o_dm_stall(o_dm_stall),
    .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
    .o_bus_wdata(o_bus_wdata), .o_bus_be(o_bus_be), .i_bus_ack(i_bus_ack),
    .i_bus_rdata(i_bus_rdata), .o_bus_err(o_bus_err)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } bus_exp_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } dm_exp_t;

  bus_exp_t      bus_q[$];
  logic [DW-1:0] if_q[$];
  dm_exp_t       dm_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none t=%0t", name, $time);
  endtask

  task automatic exp_bus(input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [BW-1:0] be);
    bus_exp_t e;
    e.we = we; e.addr = addr; e.wdata = wdata; e.be = be;
    bus_q.push_back(e);
  endtask

  task automatic exp_dm(input logic [DW-1:0] rdata, input logic err);
    dm_exp_t e;
    e.rdata = rdata; e.err = err;
    dm_q.push_back(e);
  endtask

  // ---------------- bus slave ----------------
  int               ack_delay = 1;
  bit               slave_en  = 1'b1;
  int               busy_cnt  = 0;
  logic [DW-1:0]    mem_data [logic [AW-1:0]];

  always @(negedge clk) begin
    if (o_bus_req) begin
      busy_cnt++;
      if (slave_en && busy_cnt == ack_delay) begin
        i_bus_ack   = 1'b1;
        i_bus_rdata = mem_data.exists(o_bus_addr) ? mem_data[o_bus_addr] : '0;
      end else begin
        i_bus_ack = 1'b0;
      end
    end else begin
      busy_cnt  = 0;
      i_bus_ack = 1'b0;
    end
  end

  // ---------------- monitor ----------------
  logic prev_req = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (o_bus_req && !prev_req) begin
        if (bus_q.size() == 0) begin
          unexpected("bus_req_start");
        end else begin
          bus_exp_t e;
          e = bus_q.pop_front();
          chk("bus_we", o_bus_we, e.we);
          chk("bus_addr", o_bus_addr, e.addr);
          chk("bus_be", o_bus_be, e.be);
          if (e.we) chk("bus_wdata", o_bus_wdata, e.wdata);
          $display("bus txn we=%0d addr=%08h be=%h", o_bus_we, o_bus_addr, o_bus_be);
        end
      end
      if (o_if_valid) begin
        if (if_q.size() == 0) begin
          unexpected("if_valid");
        end else begin
          logic [DW-1:0] r;
          r = if_q.pop_front();
          chk("if_rdata", o_if_rdata, r);
          chk("if_bus_err", o_bus_err, 1'b0);
          $display("if done rdata=%08h", o_if_rdata);
        end
      end
      if (o_dm_done) begin
        if (dm_q.size() == 0) begin
          unexpected("dm_done");
        end else begin
          dm_exp_t e;
          e = dm_q.pop_front();
          chk("dm_rdata", o_dm_rdata, e.rdata);
          chk("dm_bus_err", o_bus_err, e.err);
          $display("dm done rdata=%08h err=%0d", o_dm_rdata, o_bus_err);
        end
      end
      if (!o_if_valid && !o_dm_done) chk("bus_err_idle", o_bus_err, 1'b0);
      chk("if_stall", o_if_stall, i_if_req && !o_if_valid);
      chk("dm_stall", o_dm_stall, (i_dm_read || i_dm_write) && !o_dm_done);
    end
    prev_req = o_bus_req;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_if(input int lim, output int k);
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (!o_if_valid && k < lim);
    if (!o_if_valid) unexpected("if_valid_timeout");
  endtask

  task automatic wait_dm(input int lim, output int k);
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (!o_dm_done && k < lim);
    if (!o_dm_done) unexpected("dm_done_timeout");
  endtask

  task automatic wait_bus(input int lim);
    int k;
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (!o_bus_req && k < lim);
    if (!o_bus_req) unexpected("bus_req_timeout");
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int k;
    int done_n;
    reset = 1'b1;
    cyc(3);
    chk("rst_bus_req", o_bus_req, 1'b0);
    chk("rst_if_valid", o_if_valid, 1'b0);
    chk("rst_dm_done", o_dm_done, 1'b0);
    chk("rst_bus_we", o_bus_we, 1'b0);
    chk("rst_bus_addr", o_bus_addr, 32'h0);
    chk("rst_bus_be", o_bus_be, 4'h0);
    chk("rst_if_rdata", o_if_rdata, 32'h0);
    chk("rst_dm_rdata", o_dm_rdata, 32'h0);
    chk("rst_bus_err", o_bus_err, 1'b0);
    reset = 1'b0;
    cyc(1);

    // T1: fetch 0x100, ack on third busy cycle
    mem_data[32'h100] = 32'hDEADBEEF;
    ack_delay = 3;
    exp_bus(1'b0, 32'h100, 32'h0, 4'hF);
    if_q.push_back(32'hDEADBEEF);
    i_if_addr = 32'h100; i_if_req = 1'b1;
    wait_if(20, k);
    chk("t1_latency", k, 4);
    i_if_req = 1'b0;
    cyc(2);
    chk("t1_rdata_hold", o_if_rdata, 32'hDEADBEEF);

    // T2: store and fetch together -> store first, fetch right after
    ack_delay = 1;
    mem_data[32'h104] = 32'hCAFEF00D;
    exp_bus(1'b1, 32'h2000, 32'h12345678, 4'hF);
    exp_bus(1'b0, 32'h104, 32'h0, 4'hF);
    exp_dm(32'h0, 1'b0);
    if_q.push_back(32'hCAFEF00D);
    i_dm_write = 1'b1; i_dm_addr = 32'h2000; i_dm_wdata = 32'h12345678; i_dm_be = 4'hF;
    i_if_addr = 32'h104; i_if_req = 1'b1;
    wait_dm(20, k);
    chk("t2_dm_latency", k, 2);
    i_dm_write = 1'b0;
    wait_if(20, k);
    chk("t2_if_after_dm", k, 3);
    i_if_req = 1'b0;
    cyc(2);

    // T3: both pending continuously -> DM,DM,IF,DM,DM,IF
    mem_data[32'h3000] = 32'h11111111;
    mem_data[32'h200]  = 32'h22222222;
    for (int i = 0; i < 2; i++) begin
      exp_bus(1'b0, 32'h3000, 32'h0, 4'hF);
      exp_bus(1'b0, 32'h3000, 32'h0, 4'hF);
      exp_bus(1'b0, 32'h200, 32'h0, 4'hF);
      exp_dm(32'h11111111, 1'b0);
      exp_dm(32'h11111111, 1'b0);
      if_q.push_back(32'h22222222);
    end
    i_dm_read = 1'b1; i_dm_addr = 32'h3000;
    i_if_req = 1'b1; i_if_addr = 32'h200;
    done_n = 0; k = 0;
    while (done_n < 6 && k < 100) begin
      @(posedge clk); #1; k++;
      if (o_if_valid || o_dm_done) done_n++;
    end
    i_dm_read = 1'b0; i_if_req = 1'b0;
    chk("t3_completions", done_n, 6);
    cyc(3);

    // T4: reset during BUSY_DM
    slave_en = 1'b0;
    exp_bus(1'b0, 32'h4000, 32'h0, 4'hF);
    i_dm_read = 1'b1; i_dm_addr = 32'h4000;
    i_if_req = 1'b1; i_if_addr = 32'h100;
    wait_bus(10);
    cyc(2);
    #3;
    reset = 1'b1;
    #1;
    chk("t4_bus_req_async", o_bus_req, 1'b0);
    chk("t4_no_dm_done", o_dm_done, 1'b0);
    chk("t4_if_rdata_clr", o_if_rdata, 32'h0);
    chk("t4_bus_addr_clr", o_bus_addr, 32'h0);
    cyc(2);
    mem_data[32'h4000] = 32'h44444444;
    slave_en = 1'b1;
    exp_bus(1'b0, 32'h4000, 32'h0, 4'hF);
    exp_dm(32'h44444444, 1'b0);
    exp_bus(1'b0, 32'h100, 32'h0, 4'hF);
    if_q.push_back(32'hDEADBEEF);
    reset = 1'b0;
    wait_dm(20, k);
    i_dm_read = 1'b0;
    wait_if(20, k);
    i_if_req = 1'b0;
    cyc(2);

    // T6: fetch request withdrawn mid-transaction
    ack_delay = 3;
    mem_data[32'h300] = 32'h33333333;
    exp_bus(1'b0, 32'h300, 32'h0, 4'hF);
    if_q.push_back(32'h33333333);
    i_if_req = 1'b1; i_if_addr = 32'h300;
    wait_bus(10);
    i_if_req = 1'b0;
    wait_if(20, k);
    cyc(6);
    chk("t6_no_new_req", o_bus_req, 1'b0);

`ifdef MEM_ARB_TIMEOUT_EN
    // T5: no ack -> abort after 8 busy cycles
    slave_en = 1'b0;
    exp_bus(1'b0, 32'h5000, 32'h0, 4'hF);
    exp_dm(32'h0, 1'b1);
    i_dm_read = 1'b1; i_dm_addr = 32'h5000;
    wait_bus(10);
    k = 0;
    while (o_bus_req && k < 50) begin
      k++;
      @(posedge clk); #1;
    end
    chk("t5_busy_cycles", k, 8);
    chk("t5_dm_done", o_dm_done, 1'b1);
    i_dm_read = 1'b0;
    cyc(3);
    slave_en = 1'b1;
`endif

    chk("end_bus_q_empty", bus_q.size(), 0);
    chk("end_if_q_empty", if_q.size(), 0);
    chk("end_dm_q_empty", dm_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
